// File: rtl/apb_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile_if
//
// Purpose: bundles the APB bus signals between a master and the
// apb_slave_regfile register bank.
//
// Signals:
//   sel, enable, write  - PSEL / PENABLE / PWRITE (master -> slave)
//   addr                - byte address (master -> slave)
//   wdata, strb         - write data and byte strobes (master -> slave)
//   prot                - protection, bit 0 = privileged (master -> slave)
//   other_error         - injected error request, setup phase (master -> slave)
//   rdata               - registered read data (slave -> master)
//   ready               - registered PREADY (slave -> master)
//   slave_error         - registered PSLVERR, valid while ready=1 (slave -> master)
//
// Handshake: a transfer starts when sel=1 & enable=0 is sampled (setup phase).
// The master then raises enable and holds sel until it samples ready=1, which
// ends the transfer. Dropping sel before ready aborts the transfer.
// -----------------------------------------------------------------------------
interface apb_slave_regfile_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                    sel;
   logic                    enable;
   logic                    write;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] strb;
   logic [2:0]              prot;
   logic                    other_error;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    ready;
   logic                    slave_error;

   modport master (
      output sel, enable, write, addr, wdata, strb, prot, other_error,
      input  rdata, ready, slave_error
   );

   modport slave (
      input  sel, enable, write, addr, wdata, strb, prot, other_error,
      output rdata, ready, slave_error
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// Purpose: APB slave terminating transfers into a bank of REG_NUM 32-bit
// registers. Register 0 is a read-only ID; registers 1..REG_NUM-1 are
// read/write with byte strobes. Upper half of the map needs privileged
// (prot[0]=1) writes. Supports a fixed number of wait states and error
// responses for bad addresses, illegal writes and injected errors.
//
// Ports:
//   clk        - clock, rising edge
//   rstn       - synchronous active-low reset
//   bus        - APB slave modport (sel/enable/write/addr/wdata/strb/prot/
//                other_error in; rdata/ready/slave_error out, all registered)
//   dbg_state  - current FSM state (0 IDLE, 1 SETUP, 2 WAIT, 3 DONE)
//
// Handshake: a transfer is captured when sel=1 & enable=0 is sampled. With
// sel=1 & enable=1 the slave walks SETUP -> (WAIT x WAIT_CYCLES) -> DONE;
// ready=1 only in DONE. sel=0 before DONE aborts with no side effects.
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 32,   // must be 32
   parameter int                    REG_NUM     = 16,   // power of two, 4..64
   parameter int                    WAIT_CYCLES = 0,    // 0..15
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h4150_0001
) (
   input  logic                clk,
   input  logic                rstn,
   apb_slave_regfile_if.slave  bus,
   output logic [1:0]          dbg_state
);

   localparam int IDX_W  = $clog2(REG_NUM);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int BIDX_W = ADDR_WIDTH - 2;

   localparam logic [BIDX_W-1:0] REG_LIMIT  = BIDX_W'(REG_NUM);
   localparam logic [BIDX_W-1:0] PRIV_LIMIT = BIDX_W'(REG_NUM / 2);
   localparam logic [3:0]        WAIT_LOAD  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;

   // Captured setup-phase control
   logic                  wr_q, wr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     strb_q, strb_d;
   logic                  err_q, err_d;
   logic [3:0]            cnt_q, cnt_d;

   // Registered bus outputs
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  slverr_q, slverr_d;

   // Register bank; entry 0 stays zero, reads of index 0 return ID_VALUE
   logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
   logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

   logic [BIDX_W-1:0]     bus_idx;
   logic                  setup_err;
   logic                  capture;
   logic                  enter_done;
   logic                  unused_prot;

   assign bus_idx     = bus.addr[ADDR_WIDTH-1:2];
   assign unused_prot = ^bus.prot[2:1];

   // Error decision from the live setup-phase inputs; only latched on capture.
   always_comb begin
      setup_err = 1'b0;
      if (bus.addr[1:0] != 2'b00)                              setup_err = 1'b1;
      if (bus_idx >= REG_LIMIT)                                setup_err = 1'b1;
      if (bus.write && (bus_idx == '0))                        setup_err = 1'b1;
      if (bus.write && !bus.prot[0] && (bus_idx >= PRIV_LIMIT)) setup_err = 1'b1;
      if (bus.other_error)                                     setup_err = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.sel && !bus.enable) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            // enable may lag by a cycle; stay here until it shows up
            if (!bus.sel)          state_d = ST_IDLE;
            else if (bus.enable)   state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            if (!bus.sel)          state_d = ST_IDLE;
            else if (cnt_q <= 4'd1) state_d = ST_DONE;
         end
         ST_DONE: begin
            // a new setup phase right after completion chains without idling
            if (bus.sel && !bus.enable) state_d = ST_SETUP;
            else                        state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (registered, so decoded from the next state)
   // ---------------------------------------------------------------------------
   always_comb begin
      ready_d  = (state_d == ST_DONE);
      // err_q is stable here: capture never coincides with entering DONE
      slverr_d = (state_d == ST_DONE) && err_q;
   end

   // ---------------------------------------------------------------------------
   // Datapath: capture, wait counter, register commit and read return
   // ---------------------------------------------------------------------------
   always_comb begin
      capture    = (state_d == ST_SETUP) && (state_q != ST_SETUP);
      enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      regs_d  = regs_q;

      if (capture) begin
         wr_d    = bus.write;
         idx_d   = bus_idx[IDX_W-1:0];
         wdata_d = bus.wdata;
         strb_d  = bus.strb;
         err_d   = setup_err;
         cnt_d   = WAIT_LOAD;
      end else if (state_q == ST_WAIT) begin
         cnt_d = cnt_q - 4'd1;
      end

      if (enter_done) begin
         if (err_q) begin
            // errored reads return zero; errored writes leave rdata alone
            if (!wr_q) rdata_d = '0;
         end else if (wr_q) begin
            for (int i = 0; i < STRB_W; i++) begin
               if (strb_q[i]) regs_d[idx_q][8*i +: 8] = wdata_q[8*i +: 8];
            end
         end else begin
            rdata_d = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_q     <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         slverr_q <= 1'b0;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else begin
         wr_q     <= wr_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         slverr_q <= slverr_d;
         regs_q   <= regs_d;
      end
   end

   assign bus.rdata       = rdata_q;
   assign bus.ready       = ready_q;
   assign bus.slave_error = slverr_q;
   assign dbg_state       = state_q;

endmodule
